// File: rtl/rr_mux_pkg.sv
// Shared constants and picker types for the round-robin output mux.
// Optional burst-lock feature is enabled by defining RR_MUX_LOCK_EN.
package rr_mux_pkg;

  localparam int unsigned RR_N_DEF = 4;
  localparam int unsigned RR_W_DEF = 8;

  function automatic int unsigned ptr_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned PTR_W = ptr_w(RR_N_DEF);

  typedef logic [RR_N_DEF-1:0] rr_req_t;
  typedef logic [PTR_W-1:0]    rr_idx_t;

  typedef struct packed {
    rr_req_t gnt;
    rr_idx_t idx;
    logic    any;
  } rr_pick_t;

  typedef enum logic {
    LK_OPEN = 1'b0,
    LK_HELD = 1'b1
  } rr_lock_e;

endpackage

// File: rtl/rr_mux_arb_if.sv
// Requester/consumer bundle for rr_mux_arb; in_lock exists only with RR_MUX_LOCK_EN.
interface rr_mux_arb_if
  import rr_mux_pkg::*;
#(
  parameter int unsigned N = RR_N_DEF,
  parameter int unsigned W = RR_W_DEF
);

  logic [N-1:0]          in_valid;
  logic [N*W-1:0]        in_data;
  logic [N-1:0]          in_ready;
`ifdef RR_MUX_LOCK_EN
  logic [N-1:0]          in_lock;
`endif
  logic                  out_valid;
  logic [W-1:0]          out_data;
  logic [ptr_w(N)-1:0]   out_src;
  logic                  out_ready;

  modport slave (
`ifdef RR_MUX_LOCK_EN
    input  in_lock,
`endif
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_src
  );

  modport master (
`ifdef RR_MUX_LOCK_EN
    output in_lock,
`endif
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_src
  );

endinterface

// File: rtl/rr_mux_arb_pick.sv
// Combinational rotating-priority picker: first set request at or after i_ptr, wrapping.
module rr_pick
  import rr_mux_pkg::*;
#(
  parameter int unsigned N  = RR_N_DEF,
  parameter int unsigned PW = ptr_w(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);

  logic [N-1:0] w_rot;
  int unsigned  w_sum;

  // Rotate so that bit 0 is the requester at i_ptr; shifts of N clear to zero.
  assign w_rot = (i_req >> i_ptr) | (i_req << (N - 32'(i_ptr)));

  always_comb begin
    o_any = 1'b0;
    o_idx = '0;
    w_sum = 0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!o_any && w_rot[k]) begin
        o_any = 1'b1;
        w_sum = 32'(i_ptr) + k;
        if (w_sum >= N) w_sum = w_sum - N;
        o_idx = PW'(w_sum);
      end
    end
    o_gnt = o_any ? (N'(1) << o_idx) : '0;
  end

endmodule

// File: rtl/rr_mux_arb.sv
// N-way round-robin arbiter with a registered output stage and valid/ready on every port.
// Defining RR_MUX_LOCK_EN adds per-requester burst lock (in_lock) holding top priority.
module rr_mux_arb
  import rr_mux_pkg::*;
#(
  parameter int unsigned N = RR_N_DEF,
  parameter int unsigned W = RR_W_DEF
) (
  input logic          clk,
  input logic          rst,
  rr_mux_arb_if.slave  bus
);

  localparam int unsigned PW = ptr_w(N);

  logic [PW-1:0] r_ptr;
  logic          r_out_valid;
  logic [W-1:0]  r_out_data;
  logic [PW-1:0] r_out_src;

  logic          w_can_load;
  logic [N-1:0]  w_gnt;
  logic [PW-1:0] w_idx;
  logic          w_any;
  logic          w_xfer;
  logic [W-1:0]  w_sel_data;
  logic [PW-1:0] w_ptr_d;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] v);
    return (v == PW'(N - 1)) ? '0 : v + 1'b1;
  endfunction

  rr_pick #(.N(N), .PW(PW)) u_pick (
    .i_req (bus.in_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_can_load   = !r_out_valid || bus.out_ready;
  assign w_xfer       = w_any && w_can_load && !rst;
  assign bus.in_ready = w_xfer ? w_gnt : '0;

  always_comb begin
    w_sel_data = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (w_gnt[k]) w_sel_data = bus.in_data[k*W +: W];
    end
  end

`ifdef RR_MUX_LOCK_EN
  rr_lock_e r_lock;
  rr_lock_e w_lock_d;
  logic     w_lock_req;

  assign w_lock_req = |(bus.in_lock & w_gnt);

  // A held lock parks ptr on the owner; it is released by an unlocked
  // transfer or by a load opportunity where nobody (hence not the owner) is valid.
  always_comb begin
    w_ptr_d  = r_ptr;
    w_lock_d = r_lock;
    if (w_xfer) begin
      if (w_lock_req) begin
        w_lock_d = LK_HELD;
        w_ptr_d  = w_idx;
      end else begin
        w_lock_d = LK_OPEN;
        w_ptr_d  = wrap_inc(w_idx);
      end
    end else if (r_lock == LK_HELD && w_can_load) begin
      w_lock_d = LK_OPEN;
      w_ptr_d  = wrap_inc(r_ptr);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_lock <= LK_OPEN;
    else     r_lock <= w_lock_d;
  end
`else
  always_comb begin
    w_ptr_d = r_ptr;
    if (w_xfer) w_ptr_d = wrap_inc(w_idx);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= '0;
    end else begin
      r_ptr <= w_ptr_d;
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_data  <= w_sel_data;
        r_out_src   <= w_idx;
      end else if (r_out_valid && bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_src   = r_out_src;

endmodule

// File: tb/tb_rr_mux_arb.sv
// Bench for rr_mux_arb: directed scenarios plus randomized traffic against a queue-free
// behavioural model of the arbitration rules (lock rules active when RR_MUX_LOCK_EN is set).
module tb_rr_mux_arb;
  import rr_mux_pkg::*;

  localparam int unsigned N = 4;
  localparam int unsigned W = 8;
`ifdef RR_MUX_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rr_mux_arb_if #(.N(N), .W(W)) bus ();

  rr_mux_arb #(.N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  // Model state, in the specification's own terms.
  bit           m_valid = 1'b0;
  logic [W-1:0] m_data  = '0;
  int           m_src   = 0;
  int           m_ptr   = 0;
  bit           m_lock  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic int model_pick(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    end
    return -1;
  endfunction

  // Drive one cycle's inputs at negedge, compare against the model, then advance it.
  task automatic cycle(input logic r, input logic [N-1:0] v, input logic [N*W-1:0] d,
                       input logic [N-1:0] lk, input logic ordy, input bit check);
    int p;
    bit can;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    rst           = r;
    bus.in_valid  = v;
    bus.in_data   = d;
`ifdef RR_MUX_LOCK_EN
    bus.in_lock   = lk;
`endif
    bus.out_ready = ordy;
    #1;
    can = !m_valid || ordy;
    p = model_pick(v);
    exp_rdy = '0;
    if (!r && can && p >= 0) exp_rdy[p] = 1'b1;
    if (check) begin
      chk("out_valid", 32'(bus.out_valid), 32'(m_valid));
      chk("out_data",  32'(bus.out_data),  32'(m_data));
      chk("out_src",   32'(bus.out_src),   32'(m_src));
      chk("in_ready",  32'(bus.in_ready),  32'(exp_rdy));
    end
    @(posedge clk);
    if (r) begin
      m_valid = 1'b0; m_data = '0; m_src = 0; m_ptr = 0; m_lock = 1'b0;
    end else if (can && p >= 0) begin
      m_valid = 1'b1;
      m_data  = d[p*W +: W];
      m_src   = p;
      if (LOCK_EN && lk[p]) begin
        m_lock = 1'b1; m_ptr = p;
      end else begin
        m_lock = 1'b0; m_ptr = (p + 1) % N;
      end
    end else begin
      if (LOCK_EN && m_lock && can) begin
        m_lock = 1'b0; m_ptr = (m_ptr + 1) % N;
      end
      if (m_valid && ordy) m_valid = 1'b0;
    end
    #1;
  endtask

  initial begin
    logic [N*W-1:0] dseq;
    logic [N-1:0]   v;
    logic [N-1:0]   lk;
    logic [N*W-1:0] d;
    dseq = 32'hA3A2A1A0;
    bus.in_valid  = '0;
    bus.in_data   = '0;
`ifdef RR_MUX_LOCK_EN
    bus.in_lock   = '0;
`endif
    bus.out_ready = 1'b0;

    // Reset held 3 cycles with all requesters valid.
    cycle(1'b1, 4'hF, dseq, 4'h0, 1'b1, 1'b0);
    cycle(1'b1, 4'hF, dseq, 4'h0, 1'b1, 1'b1);
    cycle(1'b1, 4'hF, dseq, 4'h0, 1'b1, 1'b1);
    chk("rst_in_ready",  32'(bus.in_ready),  32'h0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_out_data",  32'(bus.out_data),  32'h0);
    chk("rst_out_src",   32'(bus.out_src),   32'h0);

    // Full rotation: A0,A1,A2,A3,A0.
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 4'hF, dseq, 4'h0, 1'b1, 1'b1);
      chk("rot_data",  32'(bus.out_data), 32'hA0 + 32'(k % 4));
      chk("rot_src",   32'(bus.out_src),  32'(k % 4));
      chk("rot_valid", 32'(bus.out_valid), 32'h1);
    end

    // Sparse requests with ptr=1: grant 2 then 0.
    cycle(1'b0, 4'b0101, dseq, 4'h0, 1'b1, 1'b1);
    chk("sparse_src0", 32'(bus.out_src), 32'd2);
    cycle(1'b0, 4'b0101, dseq, 4'h0, 1'b1, 1'b1);
    chk("sparse_src1", 32'(bus.out_src), 32'd0);

    // Backpressure with A1 held, then release with no bubble.
    cycle(1'b0, 4'hF, dseq, 4'h0, 1'b1, 1'b1);
    chk("bp_load", 32'(bus.out_data), 32'hA1);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 4'hF, dseq, 4'h0, 1'b0, 1'b1);
      chk("bp_data",  32'(bus.out_data), 32'hA1);
      chk("bp_src",   32'(bus.out_src),  32'd1);
      chk("bp_ready", 32'(bus.in_ready), 32'h0);
    end
    cycle(1'b0, 4'hF, dseq, 4'h0, 1'b1, 1'b1);
    chk("bp_release_data",  32'(bus.out_data),  32'hA2);
    chk("bp_release_valid", 32'(bus.out_valid), 32'h1);

    // Reset mid-stream discards the held word and rewinds ptr.
    cycle(1'b1, 4'hF, dseq, 4'h0, 1'b1, 1'b1);
    chk("midrst_valid", 32'(bus.out_valid), 32'h0);
    cycle(1'b0, 4'hF, dseq, 4'h0, 1'b1, 1'b1);
    chk("midrst_src", 32'(bus.out_src), 32'd0);

`ifdef RR_MUX_LOCK_EN
    // Requester 1 locks for 3 words, then drops out; grant moves to 2.
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 4'hF, dseq, 4'b0010, 1'b1, 1'b1);
      chk("lock_src", 32'(bus.out_src), 32'd1);
    end
    cycle(1'b0, 4'b1101, dseq, 4'h0, 1'b1, 1'b1);
    chk("unlock_src", 32'(bus.out_src), 32'd2);
`endif

    // Randomized traffic, occasional reset, backpressure about a quarter of the time.
    for (int it = 0; it < 400; it++) begin
      v  = N'($urandom);
      lk = N'($urandom);
      d  = $urandom;
      cycle($urandom_range(0, 63) == 0, v, d, lk, $urandom_range(0, 3) != 0, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rr_mux_arb.md
# rr_mux_arb

Round-robin arbiter with a registered output stage that shares one W-bit output channel among N requesters. It generalises the team's registered 2:1 select into an N-way, flow-controlled select, with a fair rotating priority and valid/ready handshakes on every port. It sits between multiple producer blocks and a single downstream consumer, and it owns the select sequencing so producers never drive the shared channel directly.

## Interface
- N, 4: number of requesters; legal range 2..16.
- W, 8: data width per requester.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  N  per-requester data valid.
- in_data  in  N*W  packed data; requester i occupies bits [i*W +: W].
- in_ready  out  N  per-requester accept; at most one bit set (one-hot or zero).
- in_lock  in  N  burst-lock request; this port exists only when RR_MUX_LOCK_EN is defined.
- out_valid  out  1  output register holds a word.
- out_data  out  W  registered data.
- out_src  out  clog2(N)  index of the requester that supplied out_data.
- out_ready  in  1  downstream accept.

## Operation
- Reset values: out_valid=0, out_data=0, out_src=0, priority pointer ptr=0, lock flag=0. in_ready is all-zero while rst=1.
- Load condition: can_load = !out_valid | out_ready.
- Pick: the first i with in_valid[i]=1, scanning ptr, ptr+1, … N-1, 0, … ptr-1 (mod N).
- in_ready[pick] = can_load & |in_valid. All other in_ready bits are 0. in_ready is never asserted for a requester whose in_valid=0.
- A transfer occurs on requester i when in_valid[i] & in_ready[i]. On that edge:
  - out_data <= in_data[i];
  - out_src <= i;
  - out_valid <= 1;
  - ptr <= (i+1) mod N.
- Output drain: if out_valid & out_ready and there is no transfer, then out_valid <= 0. out_data and out_src hold their values.
- Simultaneous drain and load in the same cycle: the output is replaced, out_valid stays 1, and no bubble is inserted.
- Idle (no in_valid): ptr holds.
- Stall (out_valid & !out_ready): in_ready=0 for all requesters, out_* held stable, ptr holds.
- rst asserted mid-operation: any word held in the output register is discarded. All state returns to reset values on the next edge.

## Timing
- Latency: a transfer at edge k produces out_valid=1 with that data after edge k (one cycle).
- Throughput: one word per cycle when out_ready stays high.
- in_ready is combinational from in_valid, ptr, lock state, out_valid and out_ready. There is a combinational path from out_ready to in_ready. Producers must not make in_valid depend on in_ready.
- Fairness: with all N requesters continuously valid and out_ready=1, grants rotate 0,1,…,N-1,0. Each requester waits at most N-1 grants.

## Configuration
- RR_MUX_LOCK_EN defined:
  - The in_lock port is present.
  - When requester i transfers with in_lock[i]=1, the lock flag is set and ptr <= i, not i+1, so i keeps top priority.
  - The lock flag clears on any transfer with in_lock[i]=0, or on any cycle with lock flag=1 and in_valid[i]=0 at a load opportunity. When it clears, ptr <= (i+1) mod N.
- RR_MUX_LOCK_EN not defined: the in_lock port and the lock flag are absent, and the block behaves as pure round-robin.

## Structure
- Package rr_mux_pkg:
  - PTR_W = clog2(N) helper;
  - default N/W constants;
  - rr_pick function signature typedefs.
- Sub-module rr_pick: purely combinational rotating-priority picker. Inputs are req[N] and ptr. Outputs are a one-hot grant and its index. It is reusable by other arbiters in the design.

## Test plan
- Reset: hold rst=1 for 3 cycles with all in_valid=1 → in_ready=0, out_valid=0, out_data=0, out_src=0. First grant after release goes to requester 0.
- All-request rotation: N=4, W=8, in_valid=4'b1111, data i = 8'hA0+i, out_ready=1 → out_data sequence A0,A1,A2,A3,A0, one per cycle.
- Sparse requests: only in_valid[2] and in_valid[0] set, starting with ptr=1 → grant 2 then 0. out_src sequence 2,0.
- Backpressure: out_ready=0 for 5 cycles with a word held (out_data=A1) → out_data/out_src stable, in_ready=0. Raising out_ready → A2 loads the same cycle with no bubble.
- Reset mid-stream: assert rst while out_valid=1 → next cycle out_valid=0, ptr=0.
- Lock (with RR_MUX_LOCK_EN): requester 1 sends 3 words with in_lock[1]=1 while requesters 0, 2 and 3 are all valid → out_src 1,1,1. Then requester 1 drops lock → next grant goes to 2.
